fetch_ctrl: RTL

Instruction-fetch controller that drives the program-counter register and the instruction-memory request interface. It reads the current PC, issues held-request fetches to a multicycle instruction memory, and returns the fetched instruction to decode through a valid/stall handshake. It writes the next PC back into the PC register and handles branch redirects, squashing of in-flight fetches, and halt. It sits between the PC register, instruction memory, and the decode stage.

---
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch request to instruction memory,
// presents fetched words to decode, and computes the next PC for the PC
// register (sequential +2, branch redirect, halt).
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC_out,
  output logic [15:0] PC_in,
  output logic        PCWrite,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc_plus2,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_target
);

  typedef enum logic [1:0] {REQ, FULL, FLUSH, HALT} state_t;

  state_t      state;
  logic [15:0] fetch_addr;
  logic        req_q;
  logic        valid_q;

  // req_q is low only in the first REQ cycle after reset, so the first
  // request appears the cycle after rst is first sampled high.
  assign imem_req    = rst & req_q;
  assign instr_valid = rst & valid_q;
  assign imem_addr   = fetch_addr;

  // Next-PC selection for the external PC register (Mealy).
  always_comb begin
    PC_in   = PC_out;
    PCWrite = 1'b0;
    if (!rst) begin
      PC_in   = RESET_PC;
      PCWrite = 1'b1;
    end else if (redirect) begin
      PC_in   = redirect_target;
      PCWrite = 1'b1;
    end else if (state == REQ && req_q && imem_ready) begin
      PC_in   = PC_out + 16'd2;
      PCWrite = 1'b1;
    end
  end

  // Fetch state machine with registered request/valid flags and the
  // instruction holding register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= REQ;
      fetch_addr     <= RESET_PC;
      instr          <= '0;
      instr_pc_plus2 <= '0;
      req_q          <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (redirect) begin
            req_q <= 1'b1;
            // No request was issued yet in the first post-reset cycle, so
            // there is no response to wait out.
            if (imem_ready || !req_q) begin
              fetch_addr <= redirect_target;
            end else begin
              state <= FLUSH;
            end
          end else if (imem_ready && req_q) begin
            instr          <= imem_data;
            instr_pc_plus2 <= fetch_addr + 16'd2;
            state          <= FULL;
            req_q          <= 1'b0;
            valid_q        <= 1'b1;
          end else begin
            req_q <= 1'b1;
          end
        end
        FULL: begin
          if (redirect) begin
            fetch_addr <= redirect_target;
            state      <= REQ;
            req_q      <= 1'b1;
            valid_q    <= 1'b0;
          end else if (!stall) begin
            valid_q <= 1'b0;
            if (instr[15:12] == HALT_OP) begin
              state <= HALT;
            end else begin
              fetch_addr <= PC_out;
              state      <= REQ;
              req_q      <= 1'b1;
            end
          end
        end
        FLUSH: begin
          // A redirect coinciding with the abandoned response still retires
          // that response; fetch resumes directly at the new target.
          if (redirect) begin
            if (imem_ready) begin
              fetch_addr <= redirect_target;
              state      <= REQ;
            end
          end else if (imem_ready) begin
            fetch_addr <= PC_out;
            state      <= REQ;
          end
        end
        HALT: begin
          if (redirect) begin
            fetch_addr <= redirect_target;
            state      <= REQ;
            req_q      <= 1'b1;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule
